// File: rtl/drac_pkg.sv
// Shared types and decode helpers for the IR-stage issue logic.
// Instruction classification lives here so hazard and issue logic agree.
package drac_pkg;

    localparam int NUM_SCALAR_INSTR = 2;
    localparam int REG_W = 5;

    typedef enum logic [2:0] {
        INSTR_ALU     = 3'd0,
        INSTR_ALU_IMM = 3'd1,
        INSTR_LOAD    = 3'd2,
        INSTR_STORE   = 3'd3,
        INSTR_BRANCH  = 3'd4,
        INSTR_CSR     = 3'd5,
        INSTR_FENCE   = 3'd6,
        INSTR_LUI     = 3'd7
    } instr_type_t;

    typedef struct packed {
        logic             valid;
        instr_type_t      instr_type;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             regfile_we;
    } instr_t;

    typedef struct packed {
        logic [31:0] pc;
        instr_t      instr;
    } id_ir_stage_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ir_issue_state_t;

    function automatic logic uses_rs1(input instr_t i);
        return !(i.instr_type inside {INSTR_LUI, INSTR_FENCE});
    endfunction

    function automatic logic uses_rs2(input instr_t i);
        return i.instr_type inside {INSTR_ALU, INSTR_STORE, INSTR_BRANCH};
    endfunction

    function automatic logic is_mem_instr(input instr_t i);
        return i.instr_type inside {INSTR_LOAD, INSTR_STORE};
    endfunction

    function automatic logic is_serial_instr(input instr_t i);
        return i.instr_type inside {INSTR_CSR, INSTR_FENCE};
    endfunction

    // Only slot 1 can depend on slot 0; x0 writes never create a dependency.
    function automatic logic pair_hazard(input instr_t i0, input instr_t i1);
        logic raw;
        logic waw;
        logic mem;
        raw = i0.regfile_we && (i0.rd != '0) &&
              ((uses_rs1(i1) && (i1.rs1 == i0.rd)) ||
               (uses_rs2(i1) && (i1.rs2 == i0.rd)));
        waw = i0.regfile_we && i1.regfile_we && (i0.rd == i1.rd) && (i0.rd != '0);
        mem = is_mem_instr(i0) && is_mem_instr(i1);
        return raw || waw || mem;
    endfunction

endpackage

// File: rtl/ir_issue_hazard.sv
// Intra-pair hazard detect for the two oldest queue entries.
module ir_issue_hazard
    import drac_pkg::*;
(
    input  instr_t instr0,
    input  instr_t instr1,
    output logic   hazard
);

    assign hazard = instr0.valid && instr1.valid && pair_hazard(instr0, instr1);

endmodule

// File: rtl/ir_issue_ctrl.sv
// IR-stage issue controller: picks 0/1/2 queue entries per cycle, pops them
// and registers the issued pair toward RR. Serializing ops wait for drain.
module ir_issue_ctrl
    import drac_pkg::*;
#(
    parameter int NUM_SCALAR_INSTR = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic                                 flush_i,
    input  logic                                 stall_i,
    input  logic                                 drain_done_i,
    input  id_ir_stage_t [NUM_SCALAR_INSTR-1:0] instruction_S_i,
    input  logic                                 empty_i,
    output logic         [NUM_SCALAR_INSTR-1:0] read_head_S_o,
    output id_ir_stage_t [NUM_SCALAR_INSTR-1:0] instruction_S_o,
    output logic                                 perf_dual_o,
    output logic                                 perf_hazard_o
);

    ir_issue_state_t state_q;
    ir_issue_state_t state_d;
    logic            hazard;
    logic            issue0;
    logic            issue1;
    logic            held1;

    id_ir_stage_t [NUM_SCALAR_INSTR-1:0] instr_p1;
    logic                                dual_p1;
    logic                                hazard_p1;

    ir_issue_hazard u_hazard (
        .instr0 (instruction_S_i[0].instr),
        .instr1 (instruction_S_i[1].instr),
        .hazard (hazard)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= RUN;
        else         state_q <= state_d;
    end

    // Strobes are gated by reset so the queue never pops while reset is held.
    always_comb begin
        issue0  = rstn_i && (state_q == RUN) && !stall_i && !flush_i && !empty_i &&
                  instruction_S_i[0].instr.valid;
        issue1  = issue0 && instruction_S_i[1].instr.valid && !hazard &&
                  !is_serial_instr(instruction_S_i[0].instr) &&
                  !is_serial_instr(instruction_S_i[1].instr);
        held1   = issue0 && instruction_S_i[1].instr.valid && hazard;
        state_d = state_q;
        case (state_q)
            RUN:     if (issue0 && is_serial_instr(instruction_S_i[0].instr)) state_d = DRAIN;
            DRAIN:   if (drain_done_i) state_d = RUN;
            default: state_d = RUN;
        endcase
        if (flush_i) state_d = RUN;
    end

    // IR -> RR pipeline register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            instr_p1  <= '0;
            dual_p1   <= 1'b0;
            hazard_p1 <= 1'b0;
        end else if (flush_i) begin
            instr_p1  <= '0;
            dual_p1   <= 1'b0;
            hazard_p1 <= 1'b0;
        end else begin
            dual_p1   <= issue1;
            hazard_p1 <= held1;
            if (!stall_i) begin
                instr_p1[0] <= issue0 ? instruction_S_i[0] : '0;
                instr_p1[1] <= issue1 ? instruction_S_i[1] : '0;
            end
        end
    end

    assign read_head_S_o   = {issue1, issue0};
    assign instruction_S_o = instr_p1;
    assign perf_dual_o     = dual_p1;
    assign perf_hazard_o   = hazard_p1;

endmodule

// File: doc/ir_issue_ctrl.md
# ir_issue_ctrl

Reader-side controller for the dual-slot instruction queue in the IR stage. Each cycle it inspects the two oldest queue entries and decides whether to issue 0, 1 or 2 of them, based on intra-pair hazards, serializing instructions and downstream stall. It drives the queue's per-slot read strobes and registers the issued pair into the IR→RR pipeline register.

## Interface
Parameters:
- NUM_SCALAR_INSTR, default 2 (drac_pkg): number of issue slots. Only 2 is supported.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rstn_i  in  1  reset; asynchronous, active-low
- flush_i  in  1  pipeline flush; clears the output register and state
- stall_i  in  1  RR stage cannot accept a new pair this cycle
- drain_done_i  in  1  backend is empty (no older instruction in flight)
- instruction_S_i  in  id_ir_stage_t[2]  two oldest queue entries; slot 0 is older; each qualified by instr.valid
- empty_i  in  1  queue empty
- read_head_S_o  out  1[2]  pop strobes to the queue; read_head_S_o[1] implies read_head_S_o[0]
- instruction_S_o  out  id_ir_stage_t[2]  registered issued pair; slot with instr.valid=0 is a bubble
- perf_dual_o  out  1  one-cycle pulse, registered: a pair was issued
- perf_hazard_o  out  1  one-cycle pulse, registered: slot 1 was valid but held by a hazard

## Operation
- FSM states: RUN, DRAIN. Reset and flush state: RUN.
- issue0 = RUN & ~stall_i & ~flush_i & ~empty_i & in[0].valid.
- issue1 = issue0 & in[1].valid & ~hazard & ~in[0].is_serial & ~in[1].is_serial.
- hazard (computed from package helpers on instr fields) holds when any of these is true:
  - RAW: in[0].regfile_we & rd0≠0 & ((use_rs1_1 & rs1_1==rd0) | (use_rs2_1 & rs2_1==rd0)).
  - WAW: both regfile_we with equal non-zero rd.
  - Structural: in[0].is_mem & in[1].is_mem.
- Combinational outputs: read_head_S_o[0] = issue0, read_head_S_o[1] = issue1.
- Output register on the next edge:
  - slot0 gets in[0] if issue0, else 0.
  - slot1 gets in[1] if issue1, else 0.
  - On stall_i the register holds its contents unchanged. It does not bubble.
- Serializing instructions (is_serial, i.e. CSR or fence): always issue alone in slot 0; the FSM then goes RUN→DRAIN on that edge.
- In DRAIN: no issue, and read strobes stay 0. The FSM returns DRAIN→RUN on the edge where drain_done_i=1. Issue resumes in the following cycle.
- A hazard never blocks slot 0; slot 1 simply stays in the queue and becomes the new slot 0 next cycle.

## Timing
- Reset values: instruction_S_o = 0 (both slots), read_head_S_o = 0, perf_* = 0, state = RUN.
- Latency: queue entry to instruction_S_o is 1 cycle. read_head_S_o is same-cycle combinational and has no registered path back into the queue.
- Stall: read_head_S_o = 0 during any cycle with stall_i=1. The outputs are held.
- Flush has priority over stall, drain and issue:
  - read_head_S_o = 0 in the flush cycle.
  - On the flush edge the outputs are zeroed and state goes to RUN, even from DRAIN.
- Reset mid-DRAIN returns to RUN with zeroed outputs.
- empty_i=1 forces issue0=0 regardless of stale valid bits.
- in[1].valid=0 with in[0].valid=1 gives a single issue; perf_hazard_o stays 0.
- drain_done_i is ignored in RUN.

## Structure
- drac_pkg additions:
  - ir_issue_state_t enum (RUN, DRAIN).
  - Pure functions uses_rs1, uses_rs2, is_mem_instr, is_serial_instr on the instr type.
  - Function pair_hazard(instr0, instr1) returning the hazard bit.
- One sub-module: ir_issue_hazard, a combinational wrapper around pair_hazard so it can be unit-tested alone. FSM, strobes and output register stay in ir_issue_ctrl.

## Test plan
- Independent pair (slot0 add x5; slot1 sub x6, reading x7/x8), no stall → read_head={1,1}; next cycle instruction_S_o holds both; perf_dual_o=1.
- RAW pair (slot0 writes x5; slot1 reads rs2=x5) → read_head={1,0} and perf_hazard_o=1; next cycle with the old slot1 now as slot0 → issued alone. Repeat with rd0=x0 → dual issue.
- Two loads in slots 0/1 → single issue. Load+ALU → dual issue.
- CSR in slot 0 with a valid slot 1 → CSR issues alone; state DRAIN for 3 cycles with read_head=0; drain_done_i on cycle 3 → issue resumes on cycle 4.
- stall_i high for 2 cycles with a valid pair present → read_head=0 and output held stable both cycles; stall release → pair issues.
- flush_i asserted in DRAIN, and separately together with stall_i → outputs zero on the next edge, state RUN, no read strobes. rstn_i pulse mid-operation → all outputs 0 immediately (asynchronous).
